if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of id. Owns the fetch PC and issues word requests to instruction memory.
//  Returned words, each paired with its address, are buffered in a DEPTH-entry prefetch FIFO.
//  The FIFO head drives id's inst/inst_addr inputs. Handles downstream stall and jump redirect (flush).
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC after reset (matches `INI_INST_ADDR)
//  DEPTH     2              prefetch FIFO entries; also max in-flight + buffered words (power of 2, >=2)
//  NOP_INST  32'h0000_0013  value on inst_o when FIFO empty (addi x0,x0,0)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  jump_en_i      in   1   redirect request from ex (branch taken / jal / jalr)
//  jump_addr_i    in   32  redirect target; bits[1:0] forced to 0 internally
//  stall_i        in   1   id cannot accept this cycle; head is held
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch word address (= fetch PC)
//  imem_gnt_i     in   1   request accepted this cycle (req & gnt = issue)
//  imem_rvalid_i  in   1   read data valid; responses return in issue order, latency >=1 cycle
//  imem_rdata_i   in   32  read data
//  inst_o         out  32  instruction to id (FIFO head, or NOP_INST when empty)
//  inst_addr_o    out  32  address of inst_o (0 when empty)
//  inst_valid_o   out  1   FIFO non-empty
// BEHAVIOUR
//  Reset (async, rst=1):
//   - fetch_pc=RESET_PC; FIFO count, outstanding and drop counters = 0.
//   - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
//   - imem is reset by the same rst; no pre-reset response may arrive.
//  Request credit:
//   - imem_req_o = (count + outstanding < DEPTH) & ~jump_en_i, from registered values.
//   - A pop in the same cycle does not add credit until the next cycle.
//  Issue (req & gnt):
//   - fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0).
//   - Issued address pushed into an address queue; outstanding++.
//   - Req without gnt holds imem_addr_o stable next cycle unless a jump occurs.
//  Response (rvalid):
//   - If drop_cnt > 0: discard data, drop_cnt--, outstanding--.
//   - Else push {addr, rdata} into FIFO, outstanding--.
//   - Pushed data is visible on inst_o the cycle after rvalid. Minimum gnt->inst_valid latency = 2 cycles.
//   - Issue and response in the same cycle: outstanding unchanged.
//  Pop:
//   - inst_valid_o & ~stall_i pops the head at the clock edge; the next entry (if any) appears the following cycle.
//   - Push and pop in the same cycle are both honoured (count unchanged). Overflow is impossible by credit rule.
//   - Stall with empty FIFO has no effect.
//  Redirect (jump_en_i=1, highest priority):
//   - FIFO and address queue cleared; fetch_pc={jump_addr_i[31:2],2'b00}.
//   - drop_cnt += outstanding (including any rvalid-less in-flight); an rvalid in this same cycle is dropped.
//   - imem_req_o=0 this cycle; an ungranted request is abandoned (legal).
//   - inst_valid_o=0 on the following cycle. stall_i is ignored in the jump cycle.
//   - Back-to-back jumps: last target wins; drop_cnt accumulates correctly.
//  Counter widths: count, outstanding, drop_cnt each $clog2(DEPTH)+1 bits; drop_cnt never exceeds DEPTH.
// TESTING
//  1 Reset, gnt=1, rvalid 1 cycle after gnt, no stall -> addrs 0,4,8,.. issued; inst_valid_o from cycle 2; inst_addr_o sequence 0,4,8.
//  2 stall_i=1 for 5 cycles with FIFO full (DEPTH=2) -> imem_req_o=0, inst_o/inst_addr_o held at 0x00000000/0;
//    release -> words at 0x0 then 0x4 popped on successive cycles, no loss or duplication.
//  3 jump_en_i=1, jump_addr_i=32'h0000_0103 with 2 words in flight -> both responses discarded; next issued imem_addr_o=0x100;
//    first inst_addr_o after jump = 0x100.
//  4 jump in the same cycle as rvalid and pop -> returned word dropped, inst_valid_o=0 next cycle, drop_cnt = outstanding-1.
//  5 Variable latency: gnt random, rvalid 1..4 cycles -> in-order stream, never more than DEPTH words buffered+in flight.
//  6 rst asserted mid-stream (between clock edges) -> all outputs reach reset values immediately, fetch resumes from RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to imem and
// buffers returned {addr, data} pairs in a small prefetch FIFO feeding id.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [PW-1:0] r_q_rd;
  logic [PW-1:0] r_q_wr;
  logic [PW-1:0] r_aq_rd;
  logic [PW-1:0] r_aq_wr;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_addr [DEPTH];
  logic [31:0]   r_aq     [DEPTH];

  logic          w_req;
  logic          w_issue;
  logic          w_accept;
  logic          w_drop_rsp;
  logic          w_pop;
  logic          w_valid;
  logic [CW:0]   w_credit_used;
  logic [31:0]   w_jump_pc;
  logic [CW-1:0] w_rsp;

  // Credit counts both buffered and in-flight words (including ones to be dropped)
  assign w_credit_used = (CW+1)'(r_count) + (CW+1)'(r_out);
  assign w_req         = ~rst & ~jump_en_i & (w_credit_used < (CW+1)'(DEPTH));
  assign w_issue       = w_req & imem_gnt_i;
  assign w_valid       = (r_count != '0);
  assign w_accept      = imem_rvalid_i & (r_drop == '0) & ~jump_en_i;
  assign w_drop_rsp    = imem_rvalid_i & (r_drop != '0);
  assign w_pop         = w_valid & ~stall_i & ~jump_en_i;
  assign w_jump_pc     = jump_addr_i & ~32'h0000_0003;
  assign w_rsp         = CW'(imem_rvalid_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_out   <= '0;
      r_drop  <= '0;
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_aq_rd <= '0;
      r_aq_wr <= '0;
    end else if (jump_en_i) begin
      // Every word still in flight belongs to the old stream and must be discarded
      r_pc    <= w_jump_pc;
      r_count <= '0;
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_aq_rd <= '0;
      r_aq_wr <= '0;
      r_out   <= r_out - w_rsp;
      r_drop  <= r_out - w_rsp;
    end else begin
      if (w_issue) begin
        r_pc    <= r_pc + 32'd4;
        r_aq_wr <= r_aq_wr + PW'(1);
      end
      if (w_accept) begin
        r_aq_rd <= r_aq_rd + PW'(1);
        r_q_wr  <= r_q_wr + PW'(1);
      end
      if (w_pop) begin
        r_q_rd <= r_q_rd + PW'(1);
      end
      if (w_drop_rsp) begin
        r_drop <= r_drop - CW'(1);
      end
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
      r_out   <= r_out + CW'(w_issue) - w_rsp;
    end
  end

  // Payload storage needs no reset; validity is carried by the pointers/count
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_aq[r_aq_wr] <= r_pc;
    end
    if (w_accept) begin
      r_q_inst[r_q_wr] <= imem_rdata_i;
      r_q_addr[r_q_wr] <= r_aq[r_aq_rd];
    end
  end

  assign imem_req_o   = w_req;
  assign imem_addr_o  = r_pc;
  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? r_q_inst[r_q_rd] : NOP_INST;
  assign inst_addr_o  = w_valid ? r_q_addr[r_q_rd] : 32'h0000_0000;

endmodule
